// File: rtl/cpu_pkg.sv
// Definitions shared by the fetch unit and the instruction decoder:
// fetch FSM states, instruction width and opcode encodings.
package cpu_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        STALL   = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

    localparam logic [3:0] OP_NOOP0  = 4'b0000;
    localparam logic [3:0] OP_NOOP1  = 4'b0001;
    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_SUB    = 4'b0011;
    localparam logic [3:0] OP_SHIFTL = 4'b0100;
    localparam logic [3:0] OP_SHIFTR = 4'b0101;
    localparam logic [3:0] OP_ADDI   = 4'b1100;
    localparam logic [3:0] OP_SUBI   = 4'b1111;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two circular buffer holding fetched {word, pc} entries,
// with a synchronous flush that wins over push and pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the parent masks the head while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Program counter plus fetch FSM: issues imem requests, buffers returned
// words in fetch_fifo and handles redirects that flush buffered/in-flight work.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                PC_STEP    = 4,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instruction,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               busy
);
    localparam int ENTRY_W = INSTR_W + ADDR_W;
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   disc_addr_q, disc_addr_d;

    logic                push, pop, flush;
    logic                fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic [ENTRY_W-1:0]  fifo_rdata;
    logic                fills_last_slot;

    assign flush = redirect_valid && (state_q != IDLE);
    assign push  = (state_q == FETCH) && imem_ack && !redirect_valid;
    assign pop   = !fifo_empty && instr_ready;
    assign fills_last_slot = push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH - 1));

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({imem_rdata, pc_q}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            disc_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            disc_addr_q <= disc_addr_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        disc_addr_d = disc_addr_q;
        if (redirect_valid)  pc_d = redirect_pc;
        else if (push)       pc_d = pc_q + ADDR_W'(PC_STEP);
        unique case (state_q)
            IDLE: if (start) state_d = FETCH;
            FETCH: begin
                if (redirect_valid) begin
                    // Without an ack the old request is still in flight and must be drained.
                    state_d = imem_ack ? FETCH : DISCARD;
                    if (!imem_ack) disc_addr_d = pc_q;
                end else if (fills_last_slot) begin
                    state_d = STALL;
                end
            end
            STALL:   if (redirect_valid || !fifo_full || pop) state_d = FETCH;
            DISCARD: if (imem_ack) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == FETCH) || (state_q == DISCARD);
        imem_addr   = (state_q == DISCARD) ? disc_addr_q : pc_q;
        busy        = (state_q != IDLE);
        instr_valid = !fifo_empty;
        instruction = fifo_empty ? '0 : fifo_rdata[ENTRY_W-1:ADDR_W];
        instr_pc    = fifo_empty ? '0 : fifo_rdata[ADDR_W-1:0];
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a memory responder acks
// requests, kept words are queued and compared against the FIFO head.
module tb_instruction_fetch_unit;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        busy;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        sb[$];
    logic [31:0] exp_addr = '0;
    logic [31:0] old_addr = '0;
    bit          discarding = 1'b0;
    bit          ack_enable = 1'b1;
    int          lat = 0;
    int          req_age = 0;
    int          n_acks = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A00, ~a[15:0]};
    endfunction

    // One clock: respond to imem, update the model, advance, compare the head.
    task automatic cycle();
        bit acked;
        bit req_before;
        int pre_size;
        acked      = 1'b0;
        req_before = imem_req;
        pre_size   = sb.size();
        imem_ack   = 1'b0;
        if (ack_enable && imem_req && req_age >= lat) begin
            acked      = 1'b1;
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            n_acks++;
            if (discarding) begin
                check("disc_addr", imem_addr, old_addr);
                discarding = 1'b0;
            end else begin
                check("fetch_addr", imem_addr, exp_addr);
                if (!redirect_valid) sb.push_back('{instr: mem_word(exp_addr), pc: exp_addr});
                exp_addr += 32'd4;
            end
        end
        if (redirect_valid) begin
            if (imem_req && !acked && !discarding) begin
                discarding = 1'b1;
                old_addr   = exp_addr;
            end
            exp_addr = redirect_pc;
            sb.delete();
        end else if (pre_size > 0 && instr_ready) begin
            void'(sb.pop_front());
        end
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        req_age  = acked ? 0 : (req_before ? req_age + 1 : 0);
        check("instr_valid", instr_valid, sb.size() != 0);
        if (sb.size() != 0) begin
            check("instruction", instruction, sb[0].instr);
            check("instr_pc", instr_pc, sb[0].pc);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        sb.delete();
        exp_addr = '0;
        discarding = 1'b0;
        req_age = 0;
        ack_enable = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acks_at_stall;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instruction, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Sequential fetch, ack one cycle after each request
        lat = 1;
        instr_ready = 1'b1;
        kick();
        check("busy_fetch", busy, 1);
        check("req_fetch", imem_req, 1);
        run(14);
        check("seq_acks", n_acks, 7);

        // Backpressure: FIFO fills after two words and the fetcher stalls
        do_reset();
        lat = 0;
        n_acks = 0;
        kick();
        run(2);
        check("stall_req", imem_req, 0);
        check("stall_busy", busy, 1);
        acks_at_stall = n_acks;
        run(3);
        check("stall_acks", n_acks, 2);
        check("stall_hold", n_acks, acks_at_stall);
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;
        check("resume_req", imem_req, 1);
        check("resume_addr", imem_addr, 32'h8);
        run(3);
        instr_ready = 1'b1;
        run(6);

        // Redirect while the request to 0x8 is pending; ack arrives later
        do_reset();
        lat = 0;
        instr_ready = 1'b1;
        kick();
        run(2);
        check("pend_addr", imem_addr, 32'h8);
        ack_enable = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        cycle();
        redirect_valid = 1'b0;
        check("disc_req", imem_req, 1);
        check("disc_hold", imem_addr, 32'h8);
        run(2);
        check("disc_hold2", imem_addr, 32'h8);
        ack_enable = 1'b1;
        cycle();
        check("redir_addr", imem_addr, 32'h100);
        cycle();
        check("redir_first_pc", instr_pc, 32'h100);
        run(4);

        // Redirect coincident with an ack: that word never appears
        do_reset();
        lat = 0;
        kick();
        cycle();
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        cycle();
        redirect_valid = 1'b0;
        check("coinc_empty", instr_valid, 0);
        check("coinc_addr", imem_addr, 32'h200);
        instr_ready = 1'b1;
        run(5);

        // PC wraps modulo 2^32
        do_reset();
        lat = 0;
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        kick();
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        cycle();
        check("wrap_addr1", imem_addr, 32'h0);
        run(3);

        // Asynchronous reset mid-FETCH with one buffered word
        do_reset();
        lat = 1;
        kick();
        run(2);
        check("pre_rst_valid", instr_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", instr_valid, 0);
        check("arst_instr", instruction, 0);
        check("arst_pc", instr_pc, 0);
        check("arst_req", imem_req, 0);
        check("arst_busy", busy, 0);
        check("arst_addr", imem_addr, 32'h0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        check("late_ack_valid", instr_valid, 0);
        check("late_ack_busy", busy, 0);
        check("late_ack_req", imem_req, 0);

        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
